// File: rtl/alu_pkg.sv
// Shared opcode encodings, PSR flag bit positions and FSM state encoding for alu_seq.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_ADDU = 4'd1;
    localparam logic [3:0] OP_ADDC = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_CMP  = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_NOT  = 4'd8;
    localparam logic [3:0] OP_LSH  = 4'd9;
    localparam logic [3:0] OP_RSH  = 4'd10;
    localparam logic [3:0] OP_ARSH = 4'd11;
    localparam logic [3:0] OP_MUL  = 4'd12;
    localparam logic [3:0] OP_NOP  = 4'd15;

    localparam int FZ = 4;
    localparam int FC = 3;
    localparam int FF = 2;
    localparam int FL = 1;
    localparam int FN = 0;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MUL  = 1'b1;

    typedef logic [4:0] flags_t;

    function automatic flags_t pack_flags(input logic z, input logic c, input logic f,
                                          input logic l, input logic n);
        flags_t p;
        p     = '0;
        p[FZ] = z;
        p[FC] = c;
        p[FF] = f;
        p[FL] = l;
        p[FN] = n;
        return p;
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles per product.
module alu_mul_iter #(
    parameter int WIDTH = 16,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     mcand,
    input  logic [WIDTH-1:0]     mplier,
    output logic                 last,
    output logic [2*WIDTH-1:0]   product_next
);

    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] addend;
    logic [CW-1:0]      cnt;
    logic               busy;

    assign addend       = mcand_q[cnt] ? ({{WIDTH{1'b0}}, mplier_q} << cnt) : '0;
    assign last         = busy && (cnt == CW'(WIDTH - 1));
    // The final partial sum is exposed combinationally so the owner can
    // capture the finished product on the same edge as the last step.
    assign product_next = acc + addend;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc      <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
        end else if (start) begin
            mcand_q  <= mcand;
            mplier_q <= mplier;
            acc      <= '0;
            cnt      <= '0;
            busy     <= 1'b1;
        end else if (busy) begin
            acc <= product_next;
            if (last) begin
                busy <= 1'b0;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with persistent PSR flags and an iterative multiplier behind
// a valid/ready handshake; sits between register-file reads and writeback.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             out_valid,
    output logic [4:0]       flags
);

    localparam int M = WIDTH - 1;

    logic [0:0]         state;
    logic               accept;
    logic               mul_start;
    logic               mul_last;
    logic [2*WIDTH-1:0] mul_prod;
    logic [WIDTH-1:0]   mul_lo;
    logic               mul_c;

    logic [SHW-1:0]     sh;
    logic [WIDTH:0]     add_w;
    logic [WIDTH:0]     addc_w;
    logic [WIDTH:0]     sub_w;
    logic [WIDTH:0]     lsh_w;
    logic [WIDTH:0]     rsh_w;
    logic [WIDTH:0]     arsh_w;
    logic               ovf_add;
    logic               ovf_addc;
    logic               ovf_sub;

    logic [WIDTH-1:0]   op_r;
    logic               op_c;
    logic               op_f;
    logic               op_upd;
    logic [WIDTH-1:0]   alu_res;
    logic [4:0]         alu_flags;

    assign in_ready  = (state == ST_IDLE);
    assign accept    = in_valid & in_ready;
    assign mul_start = accept && (opcode == OP_MUL);

    assign sh     = b[SHW-1:0];
    assign add_w  = {1'b0, a} + {1'b0, b};
    assign addc_w = add_w + {{WIDTH{1'b0}}, flags[FC]};
    assign sub_w  = {1'b0, a} - {1'b0, b};
    // Shifts run one bit wider so the last bit shifted out lands in a fixed
    // position; an amount of zero naturally yields carry 0.
    assign lsh_w  = {1'b0, a} << sh;
    assign rsh_w  = {a, 1'b0} >> sh;
    assign arsh_w = $signed({a, 1'b0}) >>> sh;

    assign ovf_add  = (a[M] == b[M]) && (add_w[M]  != a[M]);
    assign ovf_addc = (a[M] == b[M]) && (addc_w[M] != a[M]);
    assign ovf_sub  = (a[M] != b[M]) && (sub_w[M]  != a[M]);

    always_comb begin
        op_r      = '0;
        op_c      = 1'b0;
        op_f      = 1'b0;
        op_upd    = 1'b1;
        alu_res   = result;
        alu_flags = flags;
        case (opcode)
            OP_ADD:  begin op_r = add_w[M:0];  op_f = ovf_add; end
            OP_ADDU: begin op_r = add_w[M:0];  op_c = add_w[WIDTH]; end
            OP_ADDC: begin op_r = addc_w[M:0]; op_c = addc_w[WIDTH]; op_f = ovf_addc; end
            OP_SUB:  begin op_r = sub_w[M:0];  op_c = sub_w[WIDTH];  op_f = ovf_sub; end
            OP_AND:  op_r = a & b;
            OP_OR:   op_r = a | b;
            OP_XOR:  op_r = a ^ b;
            OP_NOT:  op_r = ~a;
            OP_LSH:  begin op_r = lsh_w[M:0];      op_c = lsh_w[WIDTH]; end
            OP_RSH:  begin op_r = rsh_w[WIDTH:1];  op_c = rsh_w[0]; end
            OP_ARSH: begin op_r = arsh_w[WIDTH:1]; op_c = arsh_w[0]; end
            default: op_upd = 1'b0;
        endcase
        if (opcode == OP_CMP) begin
            alu_res   = '0;
            alu_flags = pack_flags(a == b, 1'b0, 1'b0, a < b, $signed(a) < $signed(b));
        end else if (op_upd) begin
            alu_res   = op_r;
            alu_flags = pack_flags(op_r == '0, op_c, op_f, 1'b0, 1'b0);
        end
    end

    alu_mul_iter #(
        .WIDTH (WIDTH),
        .CW    (SHW)
    ) u_mul (
        .clk          (clk),
        .reset        (reset),
        .start        (mul_start),
        .mcand        (a),
        .mplier       (b),
        .last         (mul_last),
        .product_next (mul_prod)
    );

    assign mul_lo = mul_prod[M:0];
    assign mul_c  = |mul_prod[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            result    <= '0;
            flags     <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (opcode == OP_MUL) begin
                            state <= ST_MUL;
                        end else begin
                            result    <= alu_res;
                            flags     <= alu_flags;
                            out_valid <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    if (mul_last) begin
                        state     <= ST_IDLE;
                        result    <= mul_lo;
                        flags     <= pack_flags(mul_lo == '0, mul_c, 1'b0, 1'b0, 1'b0);
                        out_valid <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed cases followed by random operations
// compared against an arithmetic reference model of the PSR ALU.
module tb_alu_seq;

    localparam int OPC_ADD  = 0;
    localparam int OPC_ADDU = 1;
    localparam int OPC_ADDC = 2;
    localparam int OPC_SUB  = 3;
    localparam int OPC_CMP  = 4;
    localparam int OPC_AND  = 5;
    localparam int OPC_OR   = 6;
    localparam int OPC_XOR  = 7;
    localparam int OPC_NOT  = 8;
    localparam int OPC_LSH  = 9;
    localparam int OPC_RSH  = 10;
    localparam int OPC_ARSH = 11;
    localparam int OPC_MUL  = 12;
    localparam int OPC_NOP  = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  opcode;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] result;
    logic        out_valid;
    logic [4:0]  flags;

    int total = 0;
    int bad   = 0;

    int unsigned m_res = 0;
    bit m_z = 0, m_c = 0, m_f = 0, m_l = 0, m_n = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .a         (a),
        .b         (b),
        .result    (result),
        .out_valid (out_valid),
        .flags     (flags)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sx(input int unsigned v);
        return v[15] ? int'(v) - 65536 : int'(v);
    endfunction

    function automatic logic [4:0] exp_flags();
        return {m_z, m_c, m_f, m_l, m_n};
    endfunction

    function automatic bit out_of_range(input int v);
        return (v > 32767) || (v < -32768);
    endfunction

    // Reference model: integer arithmetic on the architectural PSR state.
    function automatic void model(input int op, input int unsigned ua, input int unsigned ub);
        int unsigned r, s;
        int sa, sb, n;
        longint unsigned p;
        bit c, f;
        sa = sx(ua);
        sb = sx(ub);
        n  = int'(ub & 15);
        c  = 0;
        f  = 0;
        case (op)
            OPC_ADD:  begin r = (ua + ub) & 16'hFFFF; f = out_of_range(sa + sb); end
            OPC_ADDU: begin s = ua + ub; r = s & 16'hFFFF; c = (s > 65535); end
            OPC_ADDC: begin
                s = ua + ub + int'(m_c);
                r = s & 16'hFFFF;
                f = out_of_range(sa + sb + int'(m_c));
                c = (s > 65535);
            end
            OPC_SUB:  begin r = (ua - ub) & 16'hFFFF; c = (ua < ub); f = out_of_range(sa - sb); end
            OPC_CMP:  begin
                m_res = 0; m_z = (ua == ub); m_l = (ua < ub); m_n = (sa < sb); m_c = 0; m_f = 0;
                return;
            end
            OPC_AND:  r = ua & ub;
            OPC_OR:   r = ua | ub;
            OPC_XOR:  r = ua ^ ub;
            OPC_NOT:  r = ~ua & 16'hFFFF;
            OPC_LSH:  begin r = (ua << n) & 16'hFFFF; c = (n != 0) && (((ua >> (16 - n)) & 1) != 0); end
            OPC_RSH:  begin r = ua >> n; c = (n != 0) && (((ua >> (n - 1)) & 1) != 0); end
            OPC_ARSH: begin r = int'(sa >>> n) & 16'hFFFF; c = (n != 0) && (((ua >> (n - 1)) & 1) != 0); end
            OPC_MUL:  begin p = longint'(ua) * longint'(ub); r = int'(p & 64'hFFFF); c = ((p >> 16) != 0); end
            default:  return;
        endcase
        m_res = r;
        m_z = (r == 0);
        m_c = c;
        m_f = f;
        m_l = 0;
        m_n = 0;
    endfunction

    task automatic do_op(input int op, input logic [15:0] xa, input logic [15:0] xb, input bit offer);
        int lat, lowrdy, waitc;
        @(negedge clk);
        waitc = 0;
        while (!in_ready && waitc < 40) begin
            @(negedge clk);
            waitc++;
        end
        opcode   = 4'(op);
        a        = xa;
        b        = xb;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat      = 1;
        lowrdy   = 0;
        while (!out_valid && lat < 40) begin
            if (!in_ready) lowrdy++;
            if (offer && lat == 3) begin
                in_valid = 1'b1; opcode = 4'(OPC_ADD); a = 16'h1234; b = 16'h0001;
            end
            if (offer && lat == 6) in_valid = 1'b0;
            @(negedge clk);
            lat++;
        end
        model(op, int'(xa), int'(xb));
        check("latency", lat, (op == OPC_MUL) ? 17 : 1);
        check("out_valid", out_valid, 1);
        check("result", result, m_res);
        check("flags", flags, exp_flags());
        if (op == OPC_MUL) check("mul_ready_low_cycles", lowrdy, 16);
        @(negedge clk);
        check("pulse_single", out_valid, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int op;
        logic [15:0] ra, rb;
        reset = 1'b1; in_valid = 1'b0; opcode = '0; a = '0; b = '0;
        #12;
        check("rst_result", result, 0);
        check("rst_flags", flags, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        @(negedge clk);
        reset = 1'b0;

        do_op(OPC_ADDU, 16'hFFFF, 16'h0001, 0);
        check("addu_res", result, 16'h0000);
        check("addu_flags", flags, 5'b11000);
        do_op(OPC_ADDC, 16'h0001, 16'h0001, 0);
        check("addc_res", result, 16'h0003);
        check("addc_flags", flags, 5'b00000);
        do_op(OPC_ADD, 16'h7FFF, 16'h0001, 0);
        check("add_res", result, 16'h8000);
        check("add_flags", flags, 5'b00100);
        do_op(OPC_SUB, 16'h8000, 16'h0001, 0);
        check("sub_res", result, 16'h7FFF);
        check("sub_flags", flags, 5'b00100);
        do_op(OPC_CMP, 16'hFFFF, 16'h0001, 0);
        check("cmp_res", result, 16'h0000);
        check("cmp_flags", flags, 5'b00001);
        do_op(OPC_CMP, 16'h0005, 16'h0005, 0);
        check("cmp_eq_flags", flags, 5'b10000);
        do_op(OPC_MUL, 16'h0100, 16'h0300, 1);
        check("mul_res", result, 16'h0000);
        check("mul_flags", flags, 5'b11000);

        // Back-to-back single-cycle ops: one result per cycle.
        @(negedge clk);
        in_valid = 1'b1; opcode = 4'(OPC_AND); a = 16'hF0F0; b = 16'h0FF0;
        @(negedge clk);
        model(OPC_AND, 32'hF0F0, 32'h0FF0);
        check("b2b_and_valid", out_valid, 1);
        check("b2b_and_res", result, 16'h00F0);
        check("b2b_and_flags", flags, exp_flags());
        opcode = 4'(OPC_ARSH); a = 16'h8000; b = 16'd15;
        @(negedge clk);
        model(OPC_ARSH, 32'h8000, 32'd15);
        check("b2b_arsh_valid", out_valid, 1);
        check("b2b_arsh_res", result, 16'hFFFF);
        check("b2b_arsh_flags", flags, exp_flags());
        opcode = 4'(OPC_NOP); a = 16'h1111; b = 16'h2222;
        @(negedge clk);
        in_valid = 1'b0;
        check("b2b_nop_valid", out_valid, 1);
        check("b2b_nop_res", result, 16'hFFFF);
        check("b2b_nop_flags", flags, exp_flags());
        @(negedge clk);
        check("b2b_end_valid", out_valid, 0);

        // Make flags non-zero, then abort a multiply with reset.
        do_op(OPC_ADDU, 16'hFFFF, 16'h0001, 0);
        @(negedge clk);
        opcode = 4'(OPC_MUL); a = 16'h0003; b = 16'h0005; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_flags", flags, 0);
        check("abort_result", result, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        m_res = 0; m_z = 0; m_c = 0; m_f = 0; m_l = 0; m_n = 0;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        check("abort_no_valid", cnt, 0);
        check("abort_ready_after", in_ready, 1);
        check("abort_flags_after", flags, 0);

        for (int i = 0; i < 60; i++) begin
            op = int'($urandom_range(0, 15));
            ra = 16'($urandom_range(0, 65535));
            rb = 16'($urandom_range(0, 65535));
            case ($urandom_range(0, 5))
                0: ra = 16'hFFFF;
                1: rb = 16'h8000;
                2: rb = ra;
                default: ;
            endcase
            do_op(op, ra, rb, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
